// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - parametrised register file with PC port and RAW scoreboard; macro RF_BYPASS_EN enables write-through reads
module register_file_sb #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 3,
  parameter int                PC_IDX  = 0,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              RF_A1,
  input  logic [ADDR_W-1:0]              RF_A2,
  output logic [DATA_W-1:0]              RF_D1,
  output logic [DATA_W-1:0]              RF_D2,
  input  logic [ADDR_W-1:0]              RF_A3,
  input  logic [DATA_W-1:0]              RF_D3,
  input  logic                           RF_D3_EN,
  input  logic [DATA_W-1:0]              RF_PC_W,
  input  logic                           PC_EN,
  output logic [DATA_W-1:0]              RF_PC_R,
  input  logic                           SB_SET_EN,
  input  logic [ADDR_W-1:0]              SB_SET_A,
  output logic                           RF_A1_BUSY,
  output logic                           RF_A2_BUSY,
  output logic [(2**ADDR_W)-1:0]         SB_BUSY,
  output logic [DATA_W*(2**ADDR_W)-1:0]  Reg_Flat
);

  localparam int                NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A     = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register storage: PC write first, write-back second so RF_D3 wins on a PC collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else begin
      if (PC_EN) regs[PC_A] <= RF_PC_W;
      if (RF_D3_EN) regs[RF_A3] <= RF_D3;
    end
  end

  // Pending-write scoreboard: issue sets, write-back clears, a same-cycle set wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SB_BUSY <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (SB_SET_EN && SB_SET_A == ADDR_W'(i)) SB_BUSY[i] <= 1'b1;
        else if (RF_D3_EN && RF_A3 == ADDR_W'(i)) SB_BUSY[i] <= 1'b0;
      end
    end
  end

`ifdef RF_BYPASS_EN
  logic d3_hit1, d3_hit2, d3_hit_pc;
  assign d3_hit1   = RF_D3_EN && (RF_A3 == RF_A1);
  assign d3_hit2   = RF_D3_EN && (RF_A3 == RF_A2);
  assign d3_hit_pc = RF_D3_EN && (RF_A3 == PC_A);
`endif

  // Combinational read ports, optionally forwarding this cycle's writes
  always_comb begin
    RF_D1   = regs[RF_A1];
    RF_D2   = regs[RF_A2];
    RF_PC_R = regs[PC_A];
`ifdef RF_BYPASS_EN
    if (d3_hit1) RF_D1 = RF_D3;
    else if (PC_EN && RF_A1 == PC_A) RF_D1 = RF_PC_W;
    if (d3_hit2) RF_D2 = RF_D3;
    else if (PC_EN && RF_A2 == PC_A) RF_D2 = RF_PC_W;
    if (d3_hit_pc) RF_PC_R = RF_D3;
    else if (PC_EN) RF_PC_R = RF_PC_W;
`endif
  end

  // Hazard flags; a forwarded write-back value is already usable so it is not busy
  always_comb begin
    RF_A1_BUSY = SB_BUSY[RF_A1];
    RF_A2_BUSY = SB_BUSY[RF_A2];
`ifdef RF_BYPASS_EN
    if (d3_hit1) RF_A1_BUSY = 1'b0;
    if (d3_hit2) RF_A2_BUSY = 1'b0;
`endif
  end

  // Flattened view of every register, register i at bits [i*DATA_W +: DATA_W]
  always_comb begin
    Reg_Flat = '0;
    for (int i = 0; i < NUM_REGS; i++) Reg_Flat[i*DATA_W +: DATA_W] = regs[i];
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the 8x16 register file in the dataflow units.
- Configurable data width and register count; two async read ports, one write-back port and a dedicated PC port on a configurable register index.
- Adds a per-register pending-write scoreboard so the decode stage can detect RAW hazards.
- Adds an asynchronous active-high reset.
- Sits between decode (reads, scoreboard set) and write-back (write, scoreboard clear).

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; NUM_REGS = 2**ADDR_W (derived, not overridable).
- PC_IDX, 0, index of the register used as PC.
- RST_VAL, 0, reset value of every register (DATA_W bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- RF_A1  in  ADDR_W  read address, port 1.
- RF_A2  in  ADDR_W  read address, port 2.
- RF_D1  out  DATA_W  read data, port 1.
- RF_D2  out  DATA_W  read data, port 2.
- RF_A3  in  ADDR_W  write-back address.
- RF_D3  in  DATA_W  write-back data.
- RF_D3_EN  in  1  write-back enable.
- RF_PC_W  in  DATA_W  PC write data.
- PC_EN  in  1  PC write enable.
- RF_PC_R  out  DATA_W  current PC register value.
- SB_SET_EN  in  1  mark a register as pending-write (issue).
- SB_SET_A  in  ADDR_W  register to mark.
- RF_A1_BUSY  out  1  register addressed by RF_A1 has a pending write.
- RF_A2_BUSY  out  1  register addressed by RF_A2 has a pending write.
- SB_BUSY  out  NUM_REGS  raw scoreboard vector; bit i = register i pending.
- Reg_Flat  out  DATA_W*NUM_REGS  all registers concatenated; register i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset, asynchronous, while rst=1:
  - All registers = RST_VAL.
  - All SB_BUSY bits = 0.
  - Outputs follow combinationally: RF_D1/RF_D2/RF_PC_R = RST_VAL; busy flags = 0.
  - Reset asserted mid-operation discards any write in flight.
- Reads: combinational, zero latency.
  - RF_Dn = reg[RF_An]; RF_PC_R = reg[PC_IDX].
  - Without the bypass option, a register written at edge k is visible on reads only after edge k.
- Writes, on the rising clk edge:
  - If PC_EN, reg[PC_IDX] <= RF_PC_W.
  - If RF_D3_EN, reg[RF_A3] <= RF_D3.
  - PC_EN and RF_D3_EN both set with RF_A3==PC_IDX: the RF_D3 value wins.
  - PC_EN and RF_D3_EN both set with RF_A3!=PC_IDX: both writes occur.
- Scoreboard, per register i, on the rising edge:
  - Set condition: SB_SET_EN && SB_SET_A==i.
  - Clear condition: RF_D3_EN && RF_A3==i.
  - Set and clear on the same register in the same cycle: set wins; bit stays 1 (a new producer was issued).
  - Clear of an already-clear bit: no effect, no error.
  - Set of an already-busy bit: stays 1. No counting; one outstanding producer per register.
  - PC_EN does not touch the scoreboard.
- RF_An_BUSY = SB_BUSY[RF_An], combinational.
- All width arithmetic is unsigned. Addresses are always in range, since NUM_REGS = 2**ADDR_W.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined (write-through):
  - If RF_D3_EN && RF_A3==RF_An, RF_Dn = RF_D3 in the same cycle.
  - Otherwise, if PC_EN && RF_An==PC_IDX, RF_Dn = RF_PC_W.
  - RF_PC_R is bypassed the same way, with the same RF_D3-over-PC priority.
  - RF_An_BUSY is forced to 0 when the bypass from RF_D3 applies to that port.
- Undefined:
  - Reads return stored register contents only.
  - Busy flags reflect SB_BUSY unmodified.

Test Plan:
- Reset: rst=1 mid-run after writing 0xBEEF to r3 -> r3 and RF_D1 (RF_A1=3) = 0x0000 immediately, before any clk edge; SB_BUSY = 0.
- Write/read: RF_D3_EN=1, RF_A3=5, RF_D3=0x1234, one edge; then RF_A1=5, RF_A2=5 -> RF_D1 = RF_D2 = 0x1234; Reg_Flat[95:80] = 0x1234.
- PC collision: PC_EN=1, RF_PC_W=0x0040, RF_D3_EN=1, RF_A3=0, RF_D3=0x0099 -> after the edge RF_PC_R = 0x0099. Repeat with RF_A3=2 -> RF_PC_R = 0x0040 and r2 = 0x0099.
- Scoreboard: SB_SET_EN=1, SB_SET_A=4 -> SB_BUSY = 0x10, RF_A1_BUSY=1 with RF_A1=4. Next cycle write-back to r4 -> SB_BUSY = 0x00.
- Set/clear same cycle: r6 busy; SB_SET_EN=1, SB_SET_A=6 together with RF_D3_EN=1, RF_A3=6 -> bit 6 stays 1 and r6 holds RF_D3.
- Bypass (RF_BYPASS_EN defined): RF_A1=3, RF_D3_EN=1, RF_A3=3, RF_D3=0xAAAA before the edge -> RF_D1 = 0xAAAA and RF_A1_BUSY=0 in that same cycle. With the macro undefined -> RF_D1 = old r3 value.
